// File: rtl/uart_defs.sv
// Shared UART definitions: state encodings (common with the transmitter) and bit-period formula.
package uart_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned BIT_CNT_W = 4;

    // Clocks per bit, integer division of clock frequency (MHz) by baud rate.
    function automatic int unsigned baud_cycle(input int unsigned clk_fre_mhz,
                                               input int unsigned baud_rate);
        return (clk_fre_mhz * 32'd1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus a previous-value flop for falling-edge detection.
module uart_rx_sync (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_fall_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-value chain through the synchroniser and history flop.
    always_comb begin
        sync1_d = i_rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Flops reset to the idle (high) line level so reset release never looks like a start edge.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_rx_sync = sync2_q;
    assign o_fall_c  = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start/data/optional parity/stop framing, mid-bit sampling, one-clock valid pulse.
module uart_receiver
    import uart_defs::*;
#(
    parameter int unsigned CLK_FRE     = 100,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PARITY_ON   = 0,
    parameter int unsigned PARITY_TYPE = 0,
    parameter int unsigned BAUD_RATE   = 9600
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data_rx,
    output logic                  o_data_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int unsigned CYCLE     = baud_cycle(CLK_FRE, BAUD_RATE);
    localparam int unsigned HALF_LAST = CYCLE / 2 - 1;
    localparam int unsigned BIT_LAST  = CYCLE - 1;

    logic rx_s;
    logic fall_c;

    uart_state_e              state_q,   state_d;
    logic [CNT_W-1:0]         cnt_q,     cnt_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]    shift_q,   shift_d;
    logic                     par_acc_q, par_acc_d;
    logic                     mism_q,    mism_d;
    logic [DATA_WIDTH-1:0]    data_rx_q, data_rx_d;
    logic                     valid_q,   valid_d;
    logic                     perr_q,    perr_d;
    logic                     ferr_q,    ferr_d;
    logic                     busy_q,    busy_d;
    logic                     exp_par_c;
    logic                     cnt_half_c;
    logic                     cnt_bit_c;

    uart_rx_sync u_sync (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .i_rx      (i_uart_rx),
        .o_rx_sync (rx_s),
        .o_fall_c  (fall_c)
    );

    // Bit-period compare points and expected parity for the data accumulated so far.
    always_comb begin
        cnt_half_c = (cnt_q == CNT_W'(HALF_LAST));
        cnt_bit_c  = (cnt_q == CNT_W'(BIT_LAST));
        exp_par_c  = (PARITY_TYPE == 1) ? par_acc_q : ~par_acc_q;
    end

    // Receive FSM: next state, baud counter, shift register and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        mism_d    = mism_q;
        data_rx_d = data_rx_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        unique case (state_q)
            IDLE: begin
                if (fall_c) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    par_acc_d = 1'b0;
                    mism_d    = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_half_c) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Line back high at mid start bit: treat as noise.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_bit_c) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    par_acc_d = par_acc_q ^ rx_s;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = (PARITY_ON == 1) ? PARITY : STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (cnt_bit_c) begin
                    cnt_d   = '0;
                    mism_d  = (rx_s != exp_par_c);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_bit_c) begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    cnt_d     = '0;
                    data_rx_d = shift_q;
                    valid_d   = 1'b1;
                    ferr_d    = ~rx_s;
                    perr_d    = (PARITY_ON == 1) ? mism_q : 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            mism_q    <= 1'b0;
            data_rx_q <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_acc_q <= par_acc_d;
            mism_q    <= mism_d;
            data_rx_q <= data_rx_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_data_rx    = data_rx_q;
    assign o_data_valid = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = busy_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive end of the team's serial link. It deserialises frames on i_uart_rx: 1 start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 stop bit. Each completed frame is delivered as a parallel word with a one-clock valid pulse and error flags. It sits between the board RX pin and the CPU/IO bus side, and pairs with the existing UART transmitter at the same parameter settings.

Parameters:
CLK_FRE, 100, system clock frequency in MHz
DATA_WIDTH, 8, data bits per frame (5..8)
PARITY_ON, 0, 1 = frame carries a parity bit, 0 = no parity bit
PARITY_TYPE, 0, 1 = expected parity bit equals XOR of data bits; 0 = expected parity bit equals inverted XOR
BAUD_RATE, 9600, line bit rate

Ports:
i_clk_sys  in  1  system clock; the only clock
i_rst_n  in  1  asynchronous active-low reset
i_uart_rx  in  1  serial line, asynchronous to the clock, idle high
o_data_rx  out  DATA_WIDTH  last received word
o_data_valid  out  1  one-clock pulse when a frame completes
o_parity_err  out  1  parity mismatch on the last frame
o_frame_err  out  1  stop bit sampled low on the last frame
o_busy  out  1  high whenever the state is not IDLE

Behaviour:
- One clock domain (i_clk_sys). Reset is asynchronous, active-low (i_rst_n).
- Reset values: o_data_rx=0, o_data_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0. State=IDLE, counters=0, both synchroniser flops=1.
- CYCLE = CLK_FRE*1000000/BAUD_RATE clocks per bit, using integer division. Baud counter is 32 bits and runs 0..CYCLE-1.
- i_uart_rx passes through a 2-flop synchroniser. A third flop holds the previous synchronised value for edge detection.
- IDLE: when previous=1 and current=0 (falling edge), clear the counter and go to START. A line held low never retriggers.
- START: when counter==CYCLE/2-1 (mid start bit), sample the line.
  - Sample 1: false start. Return to IDLE with no outputs changed.
  - Sample 0: clear the counter and go to DATA.
- DATA: when counter==CYCLE-1, sample the line and wrap the counter to 0.
  - Shift the sample in from the MSB side so that the first bit ends in bit 0.
  - Increment the bit count and accumulate the XOR of data bits.
  - After the DATA_WIDTH-th sample, go to PARITY if PARITY_ON=1, else to STOP.
- PARITY: when counter==CYCLE-1, sample the line. Latch mismatch = (sample != expected parity). Go to STOP.
- STOP: when counter==CYCLE-1 (mid stop bit), sample the line. On the next clock:
  - o_data_rx <= shift register.
  - o_data_valid=1 for exactly one clock.
  - o_frame_err <= ~sample.
  - o_parity_err <= mismatch (forced to 0 when PARITY_ON=0).
  - State returns to IDLE at that same edge, so a start edge arriving half a bit later is caught.
- o_data_rx and both error flags hold until the next completed frame. Frames with errors are still delivered.
- Latency: o_data_valid rises 1 clock after the mid-stop sample. That is about (DATA_WIDTH+PARITY_ON+1.5)*CYCLE+4 clocks after the pin's falling edge.
- Back-to-back frames with no idle gap are received without loss.
- Break (line stuck low): reported as a frame with o_frame_err=1. No further frames until the line returns high.
- Reset mid-frame: all state and outputs return to reset values immediately. No valid pulse is emitted for the partial frame.

Decomposition:
- Shared include/package uart_defs holds:
  - state encodings IDLE/START/DATA/PARITY/STOP, as 3-bit localparams shared with the transmitter;
  - the CYCLE formula.
- One sub-module, uart_rx_sync: 2-flop synchroniser plus previous-value flop. Outputs the synchronised line and a falling-edge strobe; reset value 1.
- FSM, baud counter and shift register live in uart_receiver.

Test Plan:
- Bench overrides CLK_FRE=1, BAUD_RATE=9600, giving CYCLE=104.
- Send frame 0xA5 with no parity, correct stop bit -> one o_data_valid pulse, o_data_rx=0xA5, both errors 0, about 990 clocks after the start edge.
- Low glitch of 20 clocks, then line high -> no valid pulse; o_busy drops about 52 clocks after the edge.
- PARITY_ON=1, PARITY_TYPE=0, data 0x03 with parity bit 1 -> o_parity_err=0. Same frame with parity bit 0 -> o_parity_err=1, o_data_rx=0x03.
- Frame 0x3C with stop bit 0, then line held low for 3 bit times -> o_frame_err=1, o_data_rx=0x3C. No second frame until the line goes high.
- Frames 0x55 then 0xAA back-to-back with no idle gap -> two valid pulses, 10*104 clocks apart (±2), with correct data.
- Assert i_rst_n low during DATA bit 4 -> all outputs 0 at once, no valid pulse. After release, frame 0x81 is received correctly.
